// File: rtl/bch_enc_ctrl_if.sv
// Handshake and remainder-register bundle between the BCH frame controller and its neighbours.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready upstream and out_valid/out_ready downstream.
interface bch_enc_ctrl_if #(
    parameter int N = 64,
    parameter int K = 40
);
    localparam int P = N - K;

    logic         in_valid;
    logic [K-1:0] in_msg;
    logic         in_ready;
    logic         rem_clr;
    logic         rem_shift;
    logic         rem_bit;
    logic [P-1:0] rem_in;
    logic         out_valid;
    logic         out_bit;
    logic         out_last;
    logic         out_ready;
    logic         busy;

    modport master (
        input  in_valid, in_msg, rem_in, out_ready,
        output in_ready, rem_clr, rem_shift, rem_bit, out_valid, out_bit, out_last, busy
    );

    modport slave (
        output in_valid, in_msg, rem_in, out_ready,
        input  in_ready, rem_clr, rem_shift, rem_bit, out_valid, out_bit, out_last, busy
    );
endinterface

// File: rtl/bch_enc_ctrl.sv
// Frame controller for the systematic shortened-BCH encoder: message in, serial codeword out.
// Latency: accept -> first codeword bit K+2 cycles; N+K+2 cycles minimum frame period.
// Backpressure: accepts only in IDLE; EMIT stalls on out_ready, ENCODE never stalls.
module bch_enc_ctrl #(
    parameter int N = 64,
    parameter int K = 40
) (
    input  logic              clk,
    input  logic              rst,
    bch_enc_ctrl_if.master    bus
);
    localparam int P  = N - K;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CLEAR, ENCODE, EMIT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [K-1:0]    msg_sr;
    logic [N-1:0]    cw;
    logic            enc_done;
    logic            emit_hs;
    logic            last_hs;

    // rem_in[0] is the highest-order parity coefficient, so it must leave first
    function automatic logic [P-1:0] bit_rev(input logic [P-1:0] v);
        logic [P-1:0] r;
        for (int i = 0; i < P; i++) begin
            r[i] = v[P-1-i];
        end
        return r;
    endfunction

    assign enc_done = (state == ENCODE) && (cnt == CW'(K-1));
    assign emit_hs  = (state == EMIT) && bus.out_ready;
    assign last_hs  = emit_hs && (cnt == CW'(N-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = CLEAR;
            CLEAR:   state_nxt = ENCODE;
            ENCODE:  if (enc_done) state_nxt = EMIT;
            EMIT:    if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            msg_sr <= '0;
            cw     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        msg_sr <= bus.in_msg;
                        cw     <= {bus.in_msg, {P{1'b0}}};
                    end
                end
                CLEAR: begin
                    cnt <= '0;
                end
                ENCODE: begin
                    msg_sr <= {msg_sr[K-2:0], 1'b0};
                    if (enc_done) begin
                        cw[P-1:0] <= bit_rev(bus.rem_in);
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                EMIT: begin
                    if (emit_hs) begin
                        cw  <= {cw[N-2:0], 1'b0};
                        cnt <= last_hs ? '0 : cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.rem_clr   = (state == CLEAR);
        bus.rem_shift = (state == ENCODE);
        bus.rem_bit   = (state == ENCODE) && msg_sr[K-1];
        bus.out_valid = (state == EMIT);
        bus.out_bit   = (state == EMIT) && cw[N-1];
        bus.out_last  = (state == EMIT) && (cnt == CW'(N-1));
    end
endmodule

// File: tb/tb_bch_enc_ctrl.sv
// Bench for bch_enc_ctrl: remainder-register environment plus polynomial-division reference.
// Latency: checks accept-to-first-bit and frame period against the cycle budget.
// Backpressure: drives out_ready randomly and checks stall stability.
module tb_bch_enc_ctrl;
    localparam int N = 64;
    localparam int K = 40;
    localparam int P = N - K;
    // generator polynomial g(x), x^24 term included
    localparam logic [P:0]   GEN      = 25'h1088211;
    // the same taps as seen by a register storing the x^23 coefficient in bit 0
    localparam logic [P-1:0] REV_TAPS = 24'h884110;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bch_enc_ctrl_if #(.N(N), .K(K)) ifc ();
    bch_enc_ctrl #(.N(N), .K(K)) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    // remainder register: presents its next-state value on rem_in
    logic [P-1:0] rem_q = 24'hA5A5A5;
    logic         rem_fb;
    assign rem_fb     = rem_q[0] ^ ifc.rem_bit;
    assign ifc.rem_in = ifc.rem_clr   ? '0 :
                        ifc.rem_shift ? ((rem_q >> 1) ^ (rem_fb ? REV_TAPS : '0)) :
                                        rem_q;
    always @(posedge clk) rem_q <= ifc.rem_in;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0] o_bits;
    logic [P-1:0] o_rem;
    logic         o_rdy_after;
    int o_hs, o_last_idx, o_shift, o_clr, o_first, o_done, o_stall_bad, o_overlap, o_rdy_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P-1:0] ref_parity(input logic [K-1:0] m);
        logic [N-1:0] r;
        r = {m, {P{1'b0}}};
        for (int i = N - 1; i >= P; i--) begin
            if (r[i]) r[i -: P+1] = r[i -: P+1] ^ GEN;
        end
        return r[P-1:0];
    endfunction

    function automatic logic [7:0] outs();
        return {ifc.in_ready, ifc.busy, ifc.rem_clr, ifc.rem_shift,
                ifc.rem_bit, ifc.out_valid, ifc.out_bit, ifc.out_last};
    endfunction

    function automatic logic [K-1:0] rand_msg();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[K-1:0];
    endfunction

    // called at a negedge; returns at the negedge of cycle 1 (CLEAR)
    task automatic accept(input logic [K-1:0] m);
        int t;
        t = 0;
        ifc.in_valid = 1'b1;
        ifc.in_msg   = m;
        while (!ifc.in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", 64'(t < 400), 64'd1);
        @(negedge clk);
    endtask

    // walks one frame from cycle 1 to the out_last handshake, then one cycle more
    task automatic observe(input int ready_pct, input bit keep_valid, input bit pulse);
        bit   stalled;
        logic hb, hl;
        stalled = 1'b0;
        hb = 1'b0;
        hl = 1'b0;
        o_bits = '0; o_rem = '0;
        o_hs = 0; o_last_idx = -1; o_shift = 0; o_clr = 0; o_first = -1; o_done = -1;
        o_stall_bad = 0; o_overlap = 0; o_rdy_bad = 0;
        if (!keep_valid) ifc.in_valid = 1'b0;
        for (int c = 1; c < 600; c++) begin
            ifc.out_ready = (int'($urandom_range(99)) < ready_pct);
            if (pulse && c == 60) begin
                ifc.in_valid = 1'b1;
                ifc.in_msg   = rand_msg();
            end else if (pulse && c == 61) begin
                ifc.in_valid = 1'b0;
            end
            if (ifc.in_ready) o_rdy_bad++;
            if (ifc.rem_clr) o_clr++;
            if (ifc.rem_clr && ifc.rem_shift) o_overlap++;
            if (ifc.rem_shift) begin
                o_shift++;
                if (o_shift == K) o_rem = ifc.rem_in;
            end
            if (ifc.out_valid) begin
                if (o_first < 0) o_first = c;
                if (stalled && (ifc.out_bit !== hb || ifc.out_last !== hl)) o_stall_bad++;
                stalled = !ifc.out_ready;
                hb = ifc.out_bit;
                hl = ifc.out_last;
                if (ifc.out_ready) begin
                    if (o_hs < N) o_bits[N-1-o_hs] = ifc.out_bit;
                    if (ifc.out_last) o_last_idx = o_hs;
                    o_hs++;
                    if (ifc.out_last) begin
                        o_done = c;
                        break;
                    end
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
        end
        @(negedge clk);
        o_rdy_after = ifc.in_ready;
        chk("frame_end_seen", 64'(o_done > 0), 64'd1);
    endtask

    task automatic check_frame(input string tag, input logic [K-1:0] m, input bit timing);
        logic [P-1:0] par, rev;
        par = ref_parity(m);
        for (int i = 0; i < P; i++) rev[i] = par[P-1-i];
        chk({tag, "_bits"},     o_bits, {m, par});
        chk({tag, "_hs"},       64'(o_hs), 64'(N));
        chk({tag, "_last_idx"}, 64'(o_last_idx), 64'(N - 1));
        chk({tag, "_shifts"},   64'(o_shift), 64'(K));
        chk({tag, "_clr"},      64'(o_clr), 64'd1);
        chk({tag, "_overlap"},  64'(o_overlap), 64'd0);
        chk({tag, "_stall"},    64'(o_stall_bad), 64'd0);
        chk({tag, "_rdy_low"},  64'(o_rdy_bad), 64'd0);
        chk({tag, "_rem_cap"},  64'(o_rem), 64'(rev));
        chk({tag, "_rdy_after"}, 64'(o_rdy_after), 64'd1);
        if (timing) begin
            chk({tag, "_first_vld"}, 64'(o_first), 64'(K + 2));
            chk({tag, "_last_cyc"},  64'(o_done), 64'(N + K + 1));
        end
    endtask

    task automatic abort_at(input string tag, input int at_c, input bit in_emit);
        accept(40'h1234567890);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (at_c - 1) @(negedge clk);
        chk({tag, "_phase"}, 64'(in_emit ? ifc.out_valid : ifc.rem_shift), 64'd1);
        rst = 1'b0;
        #1;
        chk({tag, "_outs"}, 64'(outs()), 64'h80);
        @(negedge clk);
        chk({tag, "_held"}, 64'(outs()), 64'h80);
        rst = 1'b1;
    endtask

    initial begin
        ifc.in_valid  = 1'b1;
        ifc.in_msg    = 40'hFFFFFFFFFF;
        ifc.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'(outs()), 64'h80);
        ifc.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        accept(40'h0);
        observe(100, 1'b0, 1'b0);
        check_frame("zero", 40'h0, 1'b1);
        chk("zero_all_bits", o_bits, 64'h0);

        accept(40'h1);
        observe(100, 1'b0, 1'b0);
        check_frame("one", 40'h1, 1'b1);
        chk("one_parity", 64'(o_rem), 64'h884110);

        accept(40'h1);
        observe(50, 1'b0, 1'b0);
        check_frame("one_stall", 40'h1, 1'b0);

        accept(40'h1);
        ifc.in_msg = 40'h0;
        observe(100, 1'b1, 1'b0);
        check_frame("b2b_first", 40'h1, 1'b1);
        @(negedge clk);
        observe(100, 1'b0, 1'b0);
        check_frame("b2b_second", 40'h0, 1'b1);
        chk("b2b_parity", 64'(o_rem), 64'h0);

        accept(40'hC3A5F00F96);
        observe(100, 1'b0, 1'b1);
        check_frame("emit_pulse", 40'hC3A5F00F96, 1'b1);

        for (int i = 0; i < 4; i++) begin
            logic [K-1:0] m;
            m = rand_msg();
            accept(m);
            observe(int'($urandom_range(30, 100)), 1'b0, 1'b0);
            check_frame("rand", m, 1'b0);
        end

        abort_at("rst_encode", 22, 1'b0);
        abort_at("rst_emit", K + 2 + 50, 1'b1);
        @(negedge clk);
        accept(40'h1);
        observe(100, 1'b0, 1'b0);
        check_frame("post_rst", 40'h1, 1'b1);
        chk("post_rst_parity", 64'(o_rem), 64'h884110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bch_enc_ctrl.md
# bch_enc_ctrl

Frame controller for the (N,K) systematic shortened-BCH encoder. It accepts one K-bit message word per frame over a valid/ready handshake and streams the message MSB-first into the 24-bit remainder register. It captures the remainder as N-K parity bits, then emits the N-bit codeword serially to the downstream channel/interleaver stage.

## Interface
- N, 64, codeword length in bits
- K, 40, message length in bits; P = N-K (localparam, 24) parity bits, must equal remainder register width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted 0 clears all state immediately)
- in_valid  in  1  message word available
- in_msg  in  K  message word; in_msg[K-1] is first transmitted bit
- in_ready  out  1  controller can accept a message (high only in IDLE)
- rem_clr  out  1  clear pulse to remainder register (active-high)
- rem_shift  out  1  shift enable to remainder register
- rem_bit  out  1  serial message bit to remainder register data input
- rem_in  in  P  remainder register's next-state output (remainder including the bit currently presented)
- out_valid  out  1  out_bit valid
- out_bit  out  1  serial codeword bit
- out_last  out  1  high with final (N-th) codeword bit
- out_ready  in  1  downstream accepts out_bit
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, CLEAR, ENCODE, EMIT. All outputs are decoded from registered state/datapath (Moore); no input-to-output combinational paths.
- IDLE: in_ready=1. On in_valid&&in_ready: msg_sr<=in_msg, cw[N-1:P]<=in_msg, go CLEAR.
- CLEAR: rem_clr=1 for exactly one cycle; bit counter cnt<=0; go ENCODE.
- ENCODE: rem_shift=1, rem_bit=msg_sr[K-1]; each cycle msg_sr shifts left, cnt++. In cycle cnt==K-1: cw[P-1:0]<=bit-reversed rem_in (rem_in[0] lands at cw[P-1] so it transmits first), cnt<=0, go EMIT. ENCODE lasts exactly K cycles and never stalls on out_ready.
- EMIT: out_valid=1, out_bit=cw[N-1]; on out_valid&&out_ready: cw shifts left, cnt++. out_last=1 when cnt==N-1. Handshake on the last bit -> IDLE.
- Codeword order on the wire: in_msg[K-1] ... in_msg[0], then rem_in[0] ... rem_in[P-1].
- out_bit and out_last hold stable while out_valid && !out_ready.
- cnt width: ceil(log2(N)) bits; never wraps past N-1.
- Reset values: in_ready=1 (state IDLE, inputs ignored while rst=0), busy=0, rem_clr=0, rem_shift=0, rem_bit=0, out_valid=0, out_bit=0, out_last=0, cnt=0, msg_sr=0, cw=0.
- Reset mid-frame (any state): frame discarded, return to IDLE, no partial codeword resumed. Remainder contents are irrelevant; the next frame's CLEAR pulse reinitialises them.
- in_valid outside IDLE is ignored; the upstream holds the word until in_ready.

## Timing
- Accept edge = cycle 0. CLEAR in cycle 1. ENCODE in cycles 2..K+1 (rem_shift high K cycles). First out_valid in cycle K+2.
- With out_ready held 1: out_last in cycle N+K+1; in_ready high in cycle N+K+2. Minimum frame period N+K+2 = 106 cycles (N=64, K=40).
- The parity capture samples rem_in in the same cycle as the K-th rem_shift. rem_in is the register's next-state value, so no extra cycle is needed.
- rem_clr and rem_shift are never high in the same cycle.

## Test plan
- in_msg=40'h0 with out_ready=1 -> 64 zero bits, out_last on bit 64, rem_shift high exactly 40 cycles, first out_valid 42 cycles after accept.
- in_msg=40'h1 -> parity 24'h884110. Wire stream: 39 zeros, 1, then parity LSB-first 0,0,0,0,1,0,0,0,1,0,0,0,0,0,1,0,0,0,0,1,0,0,0,1.
- Same vector with out_ready toggled pseudo-randomly (~50%) -> identical bit sequence. out_bit and out_last are stable across every stalled cycle, and exactly 64 handshakes occur.
- Back-to-back: in_valid held with 40'h1 then 40'h0 -> second word accepted only after first out_last handshake, rem_clr pulses once per frame, second frame parity 24'h000000.
- rst driven low during ENCODE (cnt=20) and again during EMIT (bit 50) -> all outputs to reset values immediately. The next frame 40'h1 yields parity 24'h884110 with no residue.
- in_valid pulsed during EMIT -> ignored, in_ready stays 0, current codeword unaffected.
